// File: rtl/leiwand_rv32_mem_arbiter.sv
// Two-master round-robin arbiter for the single-port valid/ready memory bus.
// Optional grant timeout enabled by defining LEIWAND_RV32_MEM_ARB_TIMEOUT_EN.
`ifndef MEM_WIDTH
`define MEM_WIDTH 32
`endif

module leiwand_rv32_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RESET_PRIO     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_valid,
  output logic                    m0_ready,
  input  logic [`MEM_WIDTH-1:0]   m0_addr,
  input  logic [`MEM_WIDTH-1:0]   m0_wdata,
  input  logic [3:0]              m0_wen,
  output logic [`MEM_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_valid,
  output logic                    m1_ready,
  input  logic [`MEM_WIDTH-1:0]   m1_addr,
  input  logic [`MEM_WIDTH-1:0]   m1_wdata,
  input  logic [3:0]              m1_wen,
  output logic [`MEM_WIDTH-1:0]   m1_rdata,
  output logic                    s_valid,
  input  logic                    s_ready,
  output logic [`MEM_WIDTH-1:0]   s_addr,
  output logic [`MEM_WIDTH-1:0]   s_wdata,
  output logic [3:0]              s_wen,
  input  logic [`MEM_WIDTH-1:0]   s_rdata,
  output logic                    bus_err,
  output logic [`MEM_WIDTH-1:0]   err_addr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    last_r;       // 1: master 1 was served last
  logic                    next_last_s;
  logic                    timeout_s;
  logic [`MEM_WIDTH-1:0]   done_rdata_s;

`ifdef LEIWAND_RV32_MEM_ARB_TIMEOUT_EN
  logic [7:0]              cnt_r;
  logic                    bus_err_r;
  logic [`MEM_WIDTH-1:0]   err_addr_r;

  assign timeout_s = (state_r != IDLE) && !s_ready && (cnt_r == 8'(TIMEOUT_CYCLES - 1));
  assign bus_err   = bus_err_r;
  assign err_addr  = err_addr_r;

  // Grant-cycle counter; held at zero in IDLE so it starts cleared on grant entry
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 8'd0;
    end else if (state_r == IDLE) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  // Sticky error flag; only the first timed-out address is kept
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err_r  <= 1'b0;
      err_addr_r <= '0;
    end else if (timeout_s) begin
      bus_err_r <= 1'b1;
      if (!bus_err_r) begin
        err_addr_r <= s_addr;
      end else begin
        err_addr_r <= err_addr_r;
      end
    end else begin
      bus_err_r  <= bus_err_r;
      err_addr_r <= err_addr_r;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign bus_err   = 1'b0;
  assign err_addr  = '0;
`endif

  assign done_rdata_s = s_ready ? s_rdata : `MEM_WIDTH'(32'hDEADBEEF);

  // State and last-served pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      last_r  <= (RESET_PRIO == 0) ? 1'b1 : 1'b0;
    end else begin
      state_r <= next_state_s;
      last_r  <= next_last_s;
    end
  end

  // Arbitration, slave mux and completion; s_ready is ignored in IDLE (may be stale)
  always_comb begin
    next_state_s = state_r;
    next_last_s  = last_r;
    s_valid      = 1'b0;
    s_addr       = '0;
    s_wdata      = '0;
    s_wen        = 4'b0000;
    m0_ready     = 1'b0;
    m1_ready     = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    case (state_r)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          next_state_s = last_r ? GRANT0 : GRANT1;
        end else if (m0_valid) begin
          next_state_s = GRANT0;
        end else if (m1_valid) begin
          next_state_s = GRANT1;
        end else begin
          next_state_s = IDLE;
        end
      end
      GRANT0: begin
        s_valid = 1'b1;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wen   = m0_wen;
        if (s_ready || timeout_s) begin
          m0_ready     = !reset;
          m0_rdata     = reset ? '0 : done_rdata_s;
          next_state_s = IDLE;
          next_last_s  = 1'b0;
        end else begin
          next_state_s = GRANT0;
        end
      end
      GRANT1: begin
        s_valid = 1'b1;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wen   = m1_wen;
        if (s_ready || timeout_s) begin
          m1_ready     = !reset;
          m1_rdata     = reset ? '0 : done_rdata_s;
          next_state_s = IDLE;
          next_last_s  = 1'b1;
        end else begin
          next_state_s = GRANT1;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_leiwand_rv32_mem_arbiter.sv
// Directed bench for leiwand_rv32_mem_arbiter with a registered-ready memory model.
// Checks the timeout path when LEIWAND_RV32_MEM_ARB_TIMEOUT_EN is defined.
module tb_leiwand_rv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0, m1_addr = 32'h0, m1_wdata = 32'h0;
  logic [3:0]  m0_wen = 4'h0, m1_wen = 4'h0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wen;
  logic        bus_err;
  logic [31:0] err_addr;
  logic        mem_dis = 1'b0;
  logic [31:0] mem [0:63];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  leiwand_rv32_mem_arbiter #(.TIMEOUT_CYCLES(16), .RESET_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wen(m0_wen), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wen(m1_wen), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wen(s_wen), .s_rdata(s_rdata),
    .bus_err(bus_err), .err_addr(err_addr)
  );

  // Memory model: ready registered from valid, byte writes whenever wen is non-zero
  always @(posedge clk) begin
    s_ready <= s_valid & ~mem_dis;
    s_rdata <= mem[s_addr[7:2]];
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h12345678;
      mem[8] <= 32'h11223344;
    end else begin
      for (int b = 0; b < 4; b++)
        if (s_wen[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int order[$];
    int n0, n1, wen_bad, got, gcnt, lowc, rdyc, errc;
    logic prev_done;
    logic [31:0] rd;

    // reset state
    do_reset();
    check("rst_s_valid", s_valid, 1'b0);
    check("rst_s_wen", s_wen, 4'h0);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_s_wdata", s_wdata, 32'h0);
    check("rst_m_ready", {m0_ready, m1_ready}, 2'b00);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_err_addr", err_addr, 32'h0);

    // single m0 read of word 4
    m0_addr = 32'h20400010; m0_wen = 4'h0; m0_valid = 1'b1;
    check("rd_idle_s_valid", s_valid, 1'b0);
    step();
    check("rd_grant_s_valid", s_valid, 1'b1);
    check("rd_grant_s_addr", s_addr, 32'h20400010);
    check("rd_grant_no_ready", m0_ready, 1'b0);
    step();
    check("rd_m0_ready", m0_ready, 1'b1);
    check("rd_m0_rdata", m0_rdata, 32'h12345678);
    check("rd_m1_ready", m1_ready, 1'b0);
    check("rd_m1_rdata", m1_rdata, 32'h0);
    m0_valid = 1'b0;
    step();
    check("rd_after_s_valid", s_valid, 1'b0);
    check("rd_stale_ready_ignored", m0_ready, 1'b0);
    check("rd_gated_rdata", m0_rdata, 32'h0);

    // both masters requesting continuously after reset
    do_reset();
    m0_addr = 32'h20400010; m1_addr = 32'h20400020;
    m0_valid = 1'b1; m1_valid = 1'b1;
    prev_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (prev_done) check("rr_gap", s_valid, 1'b0);
      if (m0_ready && m1_ready) check("rr_both_ready", 1'b1, 1'b0);
      if (m0_ready) begin
        order.push_back(0);
        check("rr_m0_rdata", m0_rdata, 32'h12345678);
      end
      if (m1_ready) begin
        order.push_back(1);
        check("rr_m1_rdata", m1_rdata, 32'h11223344);
      end
      prev_done = m0_ready | m1_ready;
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    check("rr_count", order.size(), 5);
    for (int k = 0; k < order.size(); k++) check("rr_order", order[k], k % 2);
    step();
    step();

    // m1 partial write while m0 holds a read
    m0_addr = 32'h20400010; m0_wen = 4'h0; m0_valid = 1'b1;
    m1_addr = 32'h20400020; m1_wdata = 32'hCAFEF00D; m1_wen = 4'b0011; m1_valid = 1'b1;
    n0 = 0; n1 = 0; wen_bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!s_valid && s_wen != 4'h0) wen_bad++;
      if (m0_ready) begin
        n0++;
        check("wr_m0_rdata", m0_rdata, 32'h12345678);
        m0_valid = 1'b0;
      end
      if (m1_ready) begin
        n1++;
        m1_valid = 1'b0;
      end
    end
    m1_wen = 4'h0;
    check("wr_m0_done", n0, 1);
    check("wr_m1_done", n1, 1);
    check("wr_idle_wen", wen_bad, 0);
    check("wr_mem_word8", mem[8], 32'h1122F00D);

    // reset in the middle of a GRANT1 access
    do_reset();
    m1_addr = 32'h20400020; m1_valid = 1'b1;
    step();
    check("rg_grant1", s_valid, 1'b1);
    check("rg_no_ready_yet", m1_ready, 1'b0);
    reset = 1'b1;
    step();
    check("rg_s_valid", s_valid, 1'b0);
    check("rg_s_addr", s_addr, 32'h0);
    check("rg_s_wen", s_wen, 4'h0);
    check("rg_m1_ready", m1_ready, 1'b0);
    check("rg_m1_rdata", m1_rdata, 32'h0);
    reset = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      step();
      if (m1_ready) begin
        got = 1;
        check("rg_later_rdata", m1_rdata, 32'h11223344);
        m1_valid = 1'b0;
      end
    end
    check("rg_later_served", got, 1);

    // slave that never responds
    mem_dis = 1'b1;
    do_reset();
    m0_addr = 32'h00000000; m0_wen = 4'h0; m0_valid = 1'b1;
`ifdef LEIWAND_RV32_MEM_ARB_TIMEOUT_EN
    for (int pass = 0; pass < 2; pass++) begin
      got = 0; gcnt = 0; rd = 32'h0;
      for (int i = 0; i < 40 && got == 0; i++) begin
        step();
        if (s_valid) gcnt++;
        if (m0_ready) begin
          got = 1;
          rd = m0_rdata;
          m0_valid = 1'b0;
        end
      end
      check("to_ready", got, 1);
      check("to_grant_cycles", gcnt, 16);
      check("to_rdata", rd, 32'hDEADBEEF);
      step();
      check("to_bus_err", bus_err, 1'b1);
      check("to_err_addr", err_addr, 32'h0);
      m0_addr = 32'h00000004; m0_valid = 1'b1;
    end
    m0_valid = 1'b0;
`else
    lowc = 0; rdyc = 0; errc = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (!s_valid) lowc++;
      if (m0_ready) rdyc++;
      if (bus_err) errc++;
    end
    check("hold_s_valid", lowc, 0);
    check("hold_no_ready", rdyc, 0);
    check("hold_bus_err", errc, 0);
    check("hold_err_addr", err_addr, 32'h0);
    m0_valid = 1'b0;
`endif
    mem_dis = 1'b0;
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
